// File: rtl/morse_pkg.sv
// morse_pkg: shared definitions for the Morse encoder.
//   state_e       - encoder FSM states
//   ASCII_*       - character constants used for decode / case folding
//   morse_code_t  - {len[2:0], pattern[3:0]} code-table entry; pattern is
//                   left-aligned, so pattern[3] is the first element sent
//                   (1 = dash)
//   to_upper()    - folds 'a'-'z' onto 'A'-'Z', passes everything else
//   max_of()      - integer max, used to size the shared timer
package morse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MARK      = 3'd1,
    ST_ELEM_GAP  = 3'd2,
    ST_CHAR_GAP  = 3'd3,
    ST_WORD_GAP  = 3'd4
  } state_e;

  localparam logic [7:0] ASCII_A         = 8'h41;
  localparam logic [7:0] ASCII_Z         = 8'h5A;
  localparam logic [7:0] ASCII_LC_A      = 8'h61;
  localparam logic [7:0] ASCII_LC_Z      = 8'h7A;
  localparam logic [7:0] ASCII_SPACE     = 8'h20;
  localparam logic [7:0] ASCII_LC_OFFSET = 8'h20;

  typedef struct packed {
    logic [2:0] len;
    logic [3:0] pattern;
  } morse_code_t;

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    if (c >= ASCII_LC_A && c <= ASCII_LC_Z) begin
      return c - ASCII_LC_OFFSET;
    end
    return c;
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/morse_rom.sv
// morse_rom: combinational International Morse lookup for upper-case A-Z.
// Ports:
//   ascii_i  in  8  upper-case ASCII byte
//   valid_o  out 1  ascii_i is a letter A-Z
//   code_o   out 7  {len, pattern}; zero when valid_o is low
module morse_rom
  import morse_pkg::*;
(
  input  logic [7:0]  ascii_i,
  output logic        valid_o,
  output morse_code_t code_o
);

  logic [7:0] offset_d;
  logic [4:0] index_d;

  assign offset_d = ascii_i - ASCII_A;
  assign index_d  = offset_d[4:0];

  always_comb begin
    valid_o = 1'b0;
    code_o  = '0;
    if (ascii_i >= ASCII_A && ascii_i <= ASCII_Z) begin
      valid_o = 1'b1;
      // Patterns are left-aligned: only the top len bits are meaningful.
      unique case (index_d)
        5'd0:  code_o = '{len: 3'd2, pattern: 4'b0100}; // A .-
        5'd1:  code_o = '{len: 3'd4, pattern: 4'b1000}; // B -...
        5'd2:  code_o = '{len: 3'd4, pattern: 4'b1010}; // C -.-.
        5'd3:  code_o = '{len: 3'd3, pattern: 4'b1000}; // D -..
        5'd4:  code_o = '{len: 3'd1, pattern: 4'b0000}; // E .
        5'd5:  code_o = '{len: 3'd4, pattern: 4'b0010}; // F ..-.
        5'd6:  code_o = '{len: 3'd3, pattern: 4'b1100}; // G --.
        5'd7:  code_o = '{len: 3'd4, pattern: 4'b0000}; // H ....
        5'd8:  code_o = '{len: 3'd2, pattern: 4'b0000}; // I ..
        5'd9:  code_o = '{len: 3'd4, pattern: 4'b0111}; // J .---
        5'd10: code_o = '{len: 3'd3, pattern: 4'b1010}; // K -.-
        5'd11: code_o = '{len: 3'd4, pattern: 4'b0100}; // L .-..
        5'd12: code_o = '{len: 3'd2, pattern: 4'b1100}; // M --
        5'd13: code_o = '{len: 3'd2, pattern: 4'b1000}; // N -.
        5'd14: code_o = '{len: 3'd3, pattern: 4'b1110}; // O ---
        5'd15: code_o = '{len: 3'd4, pattern: 4'b0110}; // P .--.
        5'd16: code_o = '{len: 3'd4, pattern: 4'b1101}; // Q --.-
        5'd17: code_o = '{len: 3'd3, pattern: 4'b0100}; // R .-.
        5'd18: code_o = '{len: 3'd3, pattern: 4'b0000}; // S ...
        5'd19: code_o = '{len: 3'd1, pattern: 4'b1000}; // T -
        5'd20: code_o = '{len: 3'd3, pattern: 4'b0010}; // U ..-
        5'd21: code_o = '{len: 3'd4, pattern: 4'b0001}; // V ...-
        5'd22: code_o = '{len: 3'd3, pattern: 4'b0110}; // W .--
        5'd23: code_o = '{len: 3'd4, pattern: 4'b1001}; // X -..-
        5'd24: code_o = '{len: 3'd4, pattern: 4'b1011}; // Y -.--
        5'd25: code_o = '{len: 3'd4, pattern: 4'b1100}; // Z --..
        default: begin
          valid_o = 1'b0;
          code_o  = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/morse_encoder.sv
// morse_encoder: serialises one ASCII character at a time as Morse key timing.
// Ports:
//   CLOCK_50    in   1  clock, rising edge
//   RESET_N     in   1  asynchronous active-low reset
//   char_in     in   8  ASCII character offered
//   char_valid  in   1  char_in valid
//   char_ready  out  1  encoder idle, character will be taken this cycle
//   key_out     out  1  registered key drive (1 = key down)
//   busy        out  1  FSM not idle
//   sym_valid   out  1  one-cycle pulse at the start of each element
//   sym_dash    out  1  element type for sym_valid (1 = dash)
//
// state       | meaning
// ------------+--------------------------------------------------
// ST_IDLE     | waiting for a character, char_ready high
// ST_MARK     | key down for one dot or dash
// ST_ELEM_GAP | key up between elements of one character
// ST_CHAR_GAP | key up after the last element of a character
// ST_WORD_GAP | key up for a space
module morse_encoder #(
  parameter int DOT_CYCLES      = 25_000_000,
  parameter int DASH_CYCLES     = 50_000_000,
  parameter int ELEM_GAP_CYCLES = 10_000_000,
  parameter int CHAR_GAP_CYCLES = 50_000_000,
  parameter int WORD_GAP_CYCLES = 100_000_000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       key_out,
  output logic       busy,
  output logic       sym_valid,
  output logic       sym_dash
);

  import morse_pkg::*;

  localparam int MAX_CYCLES = max_of(max_of(max_of(DOT_CYCLES, DASH_CYCLES),
                                            max_of(ELEM_GAP_CYCLES, CHAR_GAP_CYCLES)),
                                     WORD_GAP_CYCLES);
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);

  // Timer loads are N-1: a state lasts for the cycles the counter spends
  // on N-1 down to 0, and is left on the cycle it reads zero.
  localparam logic [CNT_W-1:0] DOT_LOAD  = CNT_W'(DOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_LOAD = CNT_W'(DASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] ELEM_LOAD = CNT_W'(ELEM_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CHAR_LOAD = CNT_W'(CHAR_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WORD_LOAD = CNT_W'(WORD_GAP_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       pat_q;     // elements still to send, next one in bit 3
  logic [2:0]       rem_q;     // elements left after the current mark
  logic             key_out_q;
  logic             sym_valid_q;
  logic             sym_dash_q;

  logic [7:0]       char_upper_d;
  logic             rom_valid_d;
  morse_code_t      rom_code_d;
  logic             accept_d;
  logic             cnt_zero_d;

  assign char_upper_d = to_upper(char_in);

  morse_rom u_rom (
    .ascii_i (char_upper_d),
    .valid_o (rom_valid_d),
    .code_o  (rom_code_d)
  );

  assign accept_d   = char_valid && (state_q == ST_IDLE);
  assign cnt_zero_d = (cnt_q == '0);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pat_q       <= '0;
      rem_q       <= '0;
      key_out_q   <= 1'b0;
      sym_valid_q <= 1'b0;
      sym_dash_q  <= 1'b0;
    end else begin
      sym_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Non-letter, non-space codes are consumed here with no effect.
          if (accept_d) begin
            if (rom_valid_d) begin
              state_q     <= ST_MARK;
              key_out_q   <= 1'b1;
              sym_valid_q <= 1'b1;
              sym_dash_q  <= rom_code_d.pattern[3];
              cnt_q       <= rom_code_d.pattern[3] ? DASH_LOAD : DOT_LOAD;
              pat_q       <= {rom_code_d.pattern[2:0], 1'b0};
              rem_q       <= rom_code_d.len - 3'd1;
            end else if (char_upper_d == ASCII_SPACE) begin
              state_q <= ST_WORD_GAP;
              cnt_q   <= WORD_LOAD;
            end
          end
        end

        ST_MARK: begin
          if (cnt_zero_d) begin
            key_out_q <= 1'b0;
            if (rem_q != 3'd0) begin
              state_q <= ST_ELEM_GAP;
              cnt_q   <= ELEM_LOAD;
            end else begin
              state_q <= ST_CHAR_GAP;
              cnt_q   <= CHAR_LOAD;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_ELEM_GAP: begin
          if (cnt_zero_d) begin
            state_q     <= ST_MARK;
            key_out_q   <= 1'b1;
            sym_valid_q <= 1'b1;
            sym_dash_q  <= pat_q[3];
            cnt_q       <= pat_q[3] ? DASH_LOAD : DOT_LOAD;
            pat_q       <= {pat_q[2:0], 1'b0};
            rem_q       <= rem_q - 3'd1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_CHAR_GAP, ST_WORD_GAP: begin
          if (cnt_zero_d) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            rem_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          cnt_q     <= '0;
          pat_q     <= '0;
          rem_q     <= '0;
          key_out_q <= 1'b0;
        end
      endcase
    end
  end

  assign char_ready = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign key_out    = key_out_q;
  assign sym_valid  = sym_valid_q;
  assign sym_dash   = sym_dash_q;

endmodule

// File: tb/tb_morse_encoder.sv
module tb_morse_encoder;

  localparam int DOT  = 4;
  localparam int DASH = 8;
  localparam int EGAP = 2;
  localparam int CGAP = 8;
  localparam int WGAP = 16;

  logic       CLOCK_50;
  logic       RESET_N;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       key_out;
  logic       busy;
  logic       sym_valid;
  logic       sym_dash;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic key;
    logic sv;
    logic sd;
    logic sd_chk;
    logic bsy;
  } exp_t;

  exp_t sb[$];

  string MORSE [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                        "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                        "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                        "-.--", "--.."};

  morse_encoder #(
    .DOT_CYCLES      (DOT),
    .DASH_CYCLES     (DASH),
    .ELEM_GAP_CYCLES (EGAP),
    .CHAR_GAP_CYCLES (CGAP),
    .WORD_GAP_CYCLES (WGAP)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .key_out    (key_out),
    .busy       (busy),
    .sym_valid  (sym_valid),
    .sym_dash   (sym_dash)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_n(input int n, input logic key, input logic bsy);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.key = key; e.sv = 1'b0; e.sd = 1'b0; e.sd_chk = 1'b0; e.bsy = bsy;
      sb.push_back(e);
    end
  endtask

  // Expected per-cycle behaviour starting the cycle after acceptance,
  // ending with one idle cycle.
  task automatic push_char(input logic [7:0] c);
    logic [7:0] u;
    string code;
    exp_t e;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    if (u >= 8'h41 && u <= 8'h5A) begin
      code = MORSE[u - 8'h41];
      for (int i = 0; i < code.len(); i++) begin
        int n;
        logic dash;
        dash = (code[i] == "-");
        n = dash ? DASH : DOT;
        e.key = 1'b1; e.sv = 1'b1; e.sd = dash; e.sd_chk = 1'b1; e.bsy = 1'b1;
        sb.push_back(e);
        push_n(n - 1, 1'b1, 1'b1);
        push_n((i == code.len() - 1) ? CGAP : EGAP, 1'b0, 1'b1);
      end
    end else if (u == 8'h20) begin
      push_n(WGAP, 1'b0, 1'b1);
    end else begin
      push_n(2, 1'b0, 1'b0);
    end
    push_n(1, 1'b0, 1'b0);
  endtask

  // Pops up to n entries, one per cycle, comparing at the falling edge.
  task automatic run_sb(input int n);
    exp_t e;
    int k;
    k = 0;
    while (sb.size() > 0 && k < n) begin
      @(negedge CLOCK_50);
      e = sb.pop_front();
      chk("key_out", key_out, e.key);
      chk("sym_valid", sym_valid, e.sv);
      if (e.sd_chk) chk("sym_dash", sym_dash, e.sd);
      chk("busy", busy, e.bsy);
      chk("char_ready", char_ready, !e.bsy);
      k++;
    end
  endtask

  // Called just after a falling edge with the encoder idle.
  task automatic offer(input logic [7:0] c);
    chk("ready_before_offer", char_ready, 1'b1);
    char_in    = c;
    char_valid = 1'b1;
    @(posedge CLOCK_50);
    #1 char_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    offer(c);
    push_char(c);
    run_sb(1000);
  endtask

  initial begin
    logic [7:0] junk [5];
    junk = '{8'h35, 8'h40, 8'h5B, 8'h60, 8'h7B};

    RESET_N    = 1'b0;
    char_in    = 8'h00;
    char_valid = 1'b0;
    #12;
    chk("rst_key_out", key_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sym_valid", sym_valid, 1'b0);
    chk("rst_sym_dash", sym_dash, 1'b0);
    chk("rst_char_ready", char_ready, 1'b1);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    @(negedge CLOCK_50);
    chk("post_rst_ready", char_ready, 1'b1);

    send(8'h45);          // E
    send(8'h41);          // A
    send(8'h71);          // q -> Q
    send(8'h5A);          // Z, top of range
    send(8'h20);          // space
    foreach (junk[i]) send(junk[i]);

    // Reset during the dash of T.
    offer(8'h54);
    push_char(8'h54);
    run_sb(3);
    sb.delete();
    #2 RESET_N = 1'b0;
    #1;
    chk("midrst_key_out", key_out, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_sym_valid", sym_valid, 1'b0);
    chk("midrst_char_ready", char_ready, 1'b1);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    push_n(3, 1'b0, 1'b0);
    run_sb(3);
    send(8'h45);

    // char_valid held across busy: E then T.
    char_in    = 8'h45;
    char_valid = 1'b1;
    @(posedge CLOCK_50);
    #1 char_in = 8'h54;
    push_char(8'h45);
    run_sb(1000);
    @(posedge CLOCK_50);
    #1 char_valid = 1'b0;
    push_char(8'h54);
    push_n(2, 1'b0, 1'b0);
    run_sb(1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/morse_encoder.md
MORSE_ENCODER -- requirements
Module: morse_encoder

Interface
REQ-001 Parameter DOT_CYCLES, default 25_000_000, SHALL set the key-down length of a dot.
REQ-002 Parameter DASH_CYCLES, default 50_000_000, SHALL set the key-down length of a dash.
REQ-003 Parameter ELEM_GAP_CYCLES, default 10_000_000, SHALL set the key-up length between elements of one character.
REQ-004 Parameter CHAR_GAP_CYCLES, default 50_000_000, SHALL set the key-up length after each character.
REQ-005 Parameter WORD_GAP_CYCLES, default 100_000_000, SHALL set the key-up length emitted for a space.
REQ-006 CLOCK_50  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-007 RESET_N  in  1  SHALL be the reset: asynchronous, active-low.
REQ-008 char_in  in  8  SHALL carry the ASCII character offered.
REQ-009 char_valid  in  1  SHALL mark char_in as valid.
REQ-010 char_ready  out  1  SHALL mark that a character can be accepted.
REQ-011 key_out  out  1  SHALL be the registered key/tone drive (1 = key down).
REQ-012 busy  out  1  SHALL be high whenever the FSM is not IDLE.
REQ-013 sym_valid  out  1  SHALL pulse for one cycle at the start of each element.
REQ-014 sym_dash  out  1  SHALL qualify sym_valid (1 = dash, 0 = dot).

Function
REQ-015 A character SHALL be accepted on a cycle with char_valid and char_ready both high; char_ready SHALL equal (state == IDLE).
REQ-016 Codes 0x41-0x5A SHALL be encoded as International Morse A-Z; 0x61-0x7A SHALL be folded to upper case first.
REQ-017 Code 0x20 SHALL produce a word gap; every other code SHALL be consumed with no key activity, and the FSM SHALL stay IDLE.
REQ-018 The lookup SHALL yield a length of 1-4 and a pattern sent MSB-first (1 = dash).
REQ-019 FSM states SHALL be IDLE, MARK, ELEM_GAP, CHAR_GAP and WORD_GAP.
REQ-020 Transitions SHALL be:
- IDLE->MARK on an accepted letter.
- IDLE->WORD_GAP on an accepted space.
- MARK->ELEM_GAP when elements remain, else MARK->CHAR_GAP.
- ELEM_GAP->MARK.
- CHAR_GAP->IDLE and WORD_GAP->IDLE.
REQ-021 key_out SHALL rise on the clock edge after acceptance and stay high for exactly DOT_CYCLES or DASH_CYCLES cycles.
REQ-022 Each gap state SHALL hold key_out low for exactly its parameter's number of cycles.
REQ-023 sym_valid and sym_dash SHALL assert on the same cycle key_out rises.
REQ-024 The down-counter SHALL be $clog2(max parameter + 1) bits wide, loaded with N-1 on state entry, and SHALL leave the state on the cycle it reads zero, so it never wraps.
REQ-025 char_valid while busy SHALL be ignored: no latch, no effect on the running character.
REQ-026 The default timing SHALL place:
- dots in (15M, 39M] cycles and dashes above 39M;
- element gaps below 15M;
- character gaps in (15M, 91M];
- a character gap plus word gap above 91M.

Reset
REQ-027 RESET_N low SHALL immediately force key_out=0, sym_valid=0, sym_dash=0 and busy=0, with state IDLE, counter 0 and the latched character cleared.
REQ-028 char_ready SHALL be 1 while reset is asserted and after release.
REQ-029 Reset mid-element SHALL abort the character; no partial element SHALL resume after release.

Structure
REQ-030 Package morse_pkg SHALL hold:
- the state enum;
- the ASCII constants (A-Z, space, lowercase offset);
- the {len[2:0], pattern[3:0]} code-table type.
REQ-031 Sub-module morse_rom SHALL map an upper-case ASCII byte to {valid, len, pattern} combinationally.

Verification (bench parameters: DOT=4, DASH=8, ELEM_GAP=2, CHAR_GAP=8, WORD_GAP=16)
REQ-032 'E' (0x45) -> key_out high for 4 cycles from the cycle after acceptance, then low for 8; one sym_valid with sym_dash=0; char_ready returns high after 12 cycles.
REQ-033 'A' (0x41) -> key_out high 4, low 2, high 8, low 8; sym_dash sequence 0,1.
REQ-034 'q' (0x71) -> key_out high 8, low 2, high 8, low 2, high 4, low 2, high 8, low 8 (--.-).
REQ-035 0x20 -> key_out low for 16 cycles with busy high and no sym_valid; '5' (0x35) -> busy never rises, char_ready stays high.
REQ-036 RESET_N dropped during the dash of 'T' -> key_out goes 0 asynchronously; after release, 'E' is sent exactly as in REQ-032.
REQ-037 char_valid held high with 'E' then 'T' queued -> 'T' is accepted only on the first cycle char_ready is high and is sent intact; nothing offered while busy is lost or duplicated.
